// File: rtl/lru_matrix_ctrl.sv
// Matrix-LRU RAM controller: forwards the load_sm init sweep, then arbitrates
// touch (read-modify-write) and victim (read-only) requests onto a single-port RAM.
module lru_matrix_ctrl #(
    parameter int SET_BITS     = 6,
    parameter int WAYS         = 4,
    parameter int WAY_BITS     = $clog2(WAYS),
    parameter int MATRIX_WIDTH = WAYS * WAYS
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    init_we_i,
    input  logic [SET_BITS-1:0]     init_addr_i,
    input  logic [MATRIX_WIDTH-1:0] init_vect_i,
    input  logic                    init_ready_i,
    input  logic                    touch_valid_i,
    input  logic [SET_BITS-1:0]     touch_set_i,
    input  logic [WAY_BITS-1:0]     touch_way_i,
    output logic                    touch_ready_o,
    input  logic                    vic_valid_i,
    input  logic [SET_BITS-1:0]     vic_set_i,
    output logic                    vic_ready_o,
    output logic                    vic_rsp_valid_o,
    output logic [WAY_BITS-1:0]     vic_way_o,
    output logic                    mem_re_o,
    output logic [SET_BITS-1:0]     mem_raddr_o,
    input  logic [MATRIX_WIDTH-1:0] mem_rdata_i,
    output logic                    mem_we_o,
    output logic [SET_BITS-1:0]     mem_waddr_o,
    output logic [MATRIX_WIDTH-1:0] mem_wdata_o,
    output logic                    init_done_o
);

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_RD   = 2'd2,
        ST_UPD  = 2'd3
    } state_t;

    state_t              state_r, state_s;
    logic                op_touch_r;
    logic [SET_BITS-1:0] set_r;
    logic [WAY_BITS-1:0] way_r;
    logic                rr_vic_r;
    logic                init_done_r;
    logic [WAY_BITS-1:0] vic_way_r;
    logic [WAY_BITS-1:0] vic_way_s;
    logic                grant_touch_s;
    logic                grant_vic_s;

    // Make way w most recent: its row set (diagonal kept 0), its column cleared.
    function automatic logic [MATRIX_WIDTH-1:0] touch_update(
        input logic [MATRIX_WIDTH-1:0] vec,
        input logic [WAY_BITS-1:0]     w
    );
        logic [MATRIX_WIDTH-1:0] res;
        res = vec;
        for (int i = 0; i < WAYS; i++) begin
            for (int j = 0; j < WAYS; j++) begin
                if (j == int'(w)) begin
                    res[i*WAYS+j] = 1'b0;
                end else if (i == int'(w)) begin
                    res[i*WAYS+j] = 1'b1;
                end else begin
                    res[i*WAYS+j] = vec[i*WAYS+j];
                end
            end
        end
        return res;
    endfunction

    // Lowest way that is more recent than no other way; 0 if the vector is corrupt.
    function automatic logic [WAY_BITS-1:0] find_victim(input logic [MATRIX_WIDTH-1:0] vec);
        logic [WAY_BITS-1:0] v;
        logic                row_zero;
        v = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            row_zero = 1'b1;
            for (int j = 0; j < WAYS; j++) begin
                row_zero = row_zero & ~((j != i) & vec[i*WAYS+j]);
            end
            v = row_zero ? WAY_BITS'(i) : v;
        end
        return v;
    endfunction

    assign vic_way_s     = find_victim(mem_rdata_i);
    assign touch_ready_o = grant_touch_s;
    assign vic_ready_o   = grant_vic_s;
    assign init_done_o   = init_done_r;

    // Round-robin grant; pointer only matters when both requesters are valid.
    always_comb begin
        grant_touch_s = 1'b0;
        grant_vic_s   = 1'b0;
        if (state_r == ST_IDLE) begin
            if (touch_valid_i && vic_valid_i) begin
                grant_touch_s = ~rr_vic_r;
                grant_vic_s   = rr_vic_r;
            end else begin
                grant_touch_s = touch_valid_i;
                grant_vic_s   = vic_valid_i;
            end
        end else begin
            grant_touch_s = 1'b0;
            grant_vic_s   = 1'b0;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_INIT: begin
                if (init_ready_i) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_INIT;
                end
            end
            ST_IDLE: begin
                if (grant_touch_s || grant_vic_s) begin
                    state_s = ST_RD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RD:   state_s = ST_UPD;
            ST_UPD:  state_s = ST_IDLE;
            default: state_s = ST_INIT;
        endcase
    end

    // State, latched request and arbitration pointer.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r     <= ST_INIT;
            op_touch_r  <= 1'b0;
            set_r       <= '0;
            way_r       <= '0;
            rr_vic_r    <= 1'b0;
            init_done_r <= 1'b0;
            vic_way_r   <= '0;
        end else begin
            state_r <= state_s;
            if (state_r == ST_INIT && init_ready_i) begin
                init_done_r <= 1'b1;
            end
            if (grant_touch_s || grant_vic_s) begin
                op_touch_r <= grant_touch_s;
                set_r      <= grant_touch_s ? touch_set_i : vic_set_i;
                way_r      <= touch_way_i;
                if (touch_valid_i && vic_valid_i) begin
                    rr_vic_r <= ~rr_vic_r;
                end
            end
            if (state_r == ST_UPD && !op_touch_r) begin
                vic_way_r <= vic_way_s;
            end
        end
    end

    // RAM port and response outputs; read data is consumed in the same cycle it arrives.
    always_comb begin
        mem_re_o        = 1'b0;
        mem_raddr_o     = set_r;
        mem_we_o        = 1'b0;
        mem_waddr_o     = '0;
        mem_wdata_o     = '0;
        vic_rsp_valid_o = 1'b0;
        vic_way_o       = vic_way_r;
        case (state_r)
            ST_INIT: begin
                mem_we_o    = init_we_i;
                mem_waddr_o = init_addr_i;
                mem_wdata_o = init_vect_i;
            end
            ST_IDLE: begin
                mem_re_o = 1'b0;
            end
            ST_RD: begin
                mem_re_o = 1'b1;
            end
            ST_UPD: begin
                if (op_touch_r) begin
                    mem_we_o    = 1'b1;
                    mem_waddr_o = set_r;
                    mem_wdata_o = touch_update(mem_rdata_i, way_r);
                end else begin
                    vic_rsp_valid_o = 1'b1;
                    vic_way_o       = vic_way_s;
                end
            end
            default: begin
                mem_re_o = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_lru_matrix_ctrl.sv
// Randomized scoreboard bench for lru_matrix_ctrl; reference keeps per-set
// recency order lists and derives matrices and victims from them.
module tb_lru_matrix_ctrl;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        init_we_i, init_ready_i;
    logic [5:0]  init_addr_i;
    logic [15:0] init_vect_i;
    logic        touch_valid_i, touch_ready_o;
    logic [5:0]  touch_set_i;
    logic [1:0]  touch_way_i;
    logic        vic_valid_i, vic_ready_o, vic_rsp_valid_o;
    logic [5:0]  vic_set_i;
    logic [1:0]  vic_way_o;
    logic        mem_re_o, mem_we_o, init_done_o;
    logic [5:0]  mem_raddr_o, mem_waddr_o;
    logic [15:0] mem_rdata_i, mem_wdata_o;

    lru_matrix_ctrl #(.SET_BITS(6), .WAYS(4)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .init_we_i(init_we_i), .init_addr_i(init_addr_i), .init_vect_i(init_vect_i),
        .init_ready_i(init_ready_i),
        .touch_valid_i(touch_valid_i), .touch_set_i(touch_set_i), .touch_way_i(touch_way_i),
        .touch_ready_o(touch_ready_o),
        .vic_valid_i(vic_valid_i), .vic_set_i(vic_set_i), .vic_ready_o(vic_ready_o),
        .vic_rsp_valid_o(vic_rsp_valid_o), .vic_way_o(vic_way_o),
        .mem_re_o(mem_re_o), .mem_raddr_o(mem_raddr_o), .mem_rdata_i(mem_rdata_i),
        .mem_we_o(mem_we_o), .mem_waddr_o(mem_waddr_o), .mem_wdata_o(mem_wdata_o),
        .init_done_o(init_done_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous single-port LRU RAM seen by the controller.
    logic [15:0] ram [64];
    always @(posedge clk) begin
        if (mem_we_o) ram[mem_waddr_o] <= mem_wdata_o;
        if (mem_re_o) mem_rdata_i <= ram[mem_raddr_o];
    end

    typedef struct {
        bit          is_touch;
        int          set;
        logic [15:0] data;
        int          way;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    bit   mon_en = 1'b0;
    int   last_vic_way = 0;

    // Reference: ord[s][0] is the most recent way, ord[s][3] the least recent.
    int ord [64][4];
    bit corrupt [64];
    bit pref_vic;
    int busy_until;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] model_vec(input int s);
        int pos [4];
        logic [15:0] v;
        v = 16'h0000;
        for (int k = 0; k < 4; k++) pos[ord[s][k]] = k;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                v[i*4+j] = (i != j) && (pos[i] < pos[j]);
        return v;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 64; s++) begin
            for (int k = 0; k < 4; k++) ord[s][k] = k;
            corrupt[s] = (s == 63);
        end
        pref_vic   = 1'b0;
        busy_until = 0;
    endtask

    task automatic model_touch(input int s, input int w);
        int k;
        k = 0;
        while (ord[s][k] != w) k++;
        for (int m = k; m > 0; m--) ord[s][m] = ord[s][m-1];
        ord[s][0] = w;
    endtask

    // One cycle of arbitration checking and scoreboard push, then input update.
    task automatic step(input bit hold);
        bit idle, exp_t_rdy, exp_v_rdy, both;
        exp_t e;
        @(negedge clk);
        idle      = (cyc >= busy_until);
        both      = touch_valid_i && vic_valid_i;
        exp_t_rdy = idle && touch_valid_i && (!vic_valid_i || !pref_vic);
        exp_v_rdy = idle && vic_valid_i && (!touch_valid_i || pref_vic);
        chk("touch_ready", touch_ready_o, exp_t_rdy);
        chk("vic_ready", vic_ready_o, exp_v_rdy);
        if (exp_t_rdy) begin
            if (both) pref_vic = 1'b1;
            model_touch(touch_set_i, touch_way_i);
            e.is_touch = 1'b1; e.set = touch_set_i; e.data = model_vec(touch_set_i);
            e.way = 0; e.cyc = cyc;
            sb.push_back(e);
            busy_until = cyc + 3;
        end else if (exp_v_rdy) begin
            if (both) pref_vic = 1'b0;
            e.is_touch = 1'b0; e.set = vic_set_i; e.data = 16'h0000;
            e.way = corrupt[vic_set_i] ? 0 : ord[vic_set_i][3]; e.cyc = cyc;
            sb.push_back(e);
            busy_until = cyc + 3;
        end
        @(posedge clk); #1;
        if (!hold && exp_t_rdy) touch_valid_i = 1'b0;
        if (!hold && exp_v_rdy) vic_valid_i = 1'b0;
    endtask

    task automatic do_op(input bit is_touch, input int s, input int w);
        if (is_touch) begin
            touch_valid_i = 1'b1; touch_set_i = 6'(s); touch_way_i = 2'(w);
        end else begin
            vic_valid_i = 1'b1; vic_set_i = 6'(s);
        end
        repeat (4) step(1'b0);
    endtask

    // load_sm sweep: 0x08CE everywhere except a corrupt all-ones vector in set 63.
    task automatic sweep();
        touch_valid_i = 1'b1; vic_valid_i = 1'b1;
        for (int a = 0; a < 64; a++) begin
            if (a % 16 == 5) begin
                init_we_i = 1'b0;
                @(negedge clk);
                chk("init_gap_we", mem_we_o, 1'b0);
                @(posedge clk); #1;
            end
            init_we_i   = 1'b1;
            init_addr_i = 6'(a);
            init_vect_i = (a == 63) ? 16'hFFFF : 16'h08CE;
            @(negedge clk);
            chk("init_we", mem_we_o, 1'b1);
            chk("init_waddr", mem_waddr_o, init_addr_i);
            chk("init_wdata", mem_wdata_o, init_vect_i);
            chk("init_t_ready", touch_ready_o, 1'b0);
            chk("init_v_ready", vic_ready_o, 1'b0);
            chk("init_done_early", init_done_o, 1'b0);
            @(posedge clk); #1;
        end
        init_we_i = 1'b0; init_ready_i = 1'b1;
        touch_valid_i = 1'b0; vic_valid_i = 1'b0;
        @(negedge clk);
        chk("init_done_same", init_done_o, 1'b0);
        @(posedge clk); #1;
        init_ready_i = 1'b0;
        @(negedge clk);
        chk("init_done_next", init_done_o, 1'b1);
        @(posedge clk); #1;
        model_reset();
    endtask

    // Monitor: pops the scoreboard whenever the controller writes or responds.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                last_vic_way = 0;
            end else begin
                if (mem_re_o) begin
                    if (sb.size() == 0) chk("re_spurious", 1'b1, 1'b0);
                    else begin
                        chk("re_cycle", cyc, sb[0].cyc + 1);
                        chk("re_addr", mem_raddr_o, sb[0].set);
                    end
                end
                if (mem_we_o || vic_rsp_valid_o) begin
                    if (sb.size() == 0) chk("rsp_spurious", 1'b1, 1'b0);
                    else begin
                        e = sb.pop_front();
                        chk("rsp_type", mem_we_o, e.is_touch);
                        chk("rsp_cycle", cyc, e.cyc + 2);
                        if (e.is_touch) begin
                            chk("wr_addr", mem_waddr_o, e.set);
                            chk("wr_data", mem_wdata_o, e.data);
                        end else begin
                            chk("vic_way", vic_way_o, e.way);
                            last_vic_way = e.way;
                        end
                    end
                end else begin
                    chk("vic_hold", vic_way_o, last_vic_way);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b1; init_we_i = 1'b0; init_ready_i = 1'b0;
        init_addr_i = 6'd0; init_vect_i = 16'h0000;
        touch_valid_i = 1'b0; touch_set_i = 6'd0; touch_way_i = 2'd0;
        vic_valid_i = 1'b0; vic_set_i = 6'd0;
        model_reset();
        #12;
        chk("rst_mem_re", mem_re_o, 1'b0);
        chk("rst_mem_we", mem_we_o, 1'b0);
        chk("rst_vic_rsp", vic_rsp_valid_o, 1'b0);
        chk("rst_vic_way", vic_way_o, 2'd0);
        chk("rst_init_done", init_done_o, 1'b0);
        @(posedge clk); #1;
        rst_i = 1'b0;
        sweep();
        mon_en = 1'b1;

        do_op(1'b1, 5, 3);   // 0x08CE -> 0x7046
        do_op(1'b0, 5, 0);   // victim way 2
        do_op(1'b0, 6, 0);   // untouched: way 3
        do_op(1'b0, 63, 0);  // corrupt: way 0

        touch_valid_i = 1'b1; touch_set_i = 6'd10; touch_way_i = 2'd1;
        vic_valid_i = 1'b1; vic_set_i = 6'd10;
        repeat (18) step(1'b1);
        touch_valid_i = 1'b0; vic_valid_i = 1'b0;
        repeat (4) step(1'b0);

        for (int n = 0; n < 400; n++) begin
            step(1'b0);
            if (!touch_valid_i && $urandom_range(0, 2) == 0) begin
                touch_valid_i = 1'b1;
                touch_set_i = 6'($urandom_range(0, 62));
                touch_way_i = 2'($urandom_range(0, 3));
            end
            if (!vic_valid_i && $urandom_range(0, 2) == 0) begin
                vic_valid_i = 1'b1;
                vic_set_i = 6'($urandom_range(0, 63));
            end
        end
        touch_valid_i = 1'b0; vic_valid_i = 1'b0;
        repeat (4) step(1'b0);
        chk("sb_drained", sb.size(), 0);

        // Reset while a touch is in its read cycle.
        mon_en = 1'b0;
        touch_valid_i = 1'b1; touch_set_i = 6'd20; touch_way_i = 2'd1;
        step(1'b0);
        @(negedge clk);
        chk("rd_before_rst", mem_re_o, 1'b1);
        #1 rst_i = 1'b1;
        #1;
        chk("async_mem_re", mem_re_o, 1'b0);
        chk("async_init_done", init_done_o, 1'b0);
        chk("async_vic_way", vic_way_o, 2'd0);
        @(posedge clk); #1;
        rst_i = 1'b0;
        sb.delete();
        touch_valid_i = 1'b1; vic_valid_i = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("post_rst_we", mem_we_o, 1'b0);
            chk("post_rst_t_ready", touch_ready_o, 1'b0);
            chk("post_rst_v_ready", vic_ready_o, 1'b0);
            chk("post_rst_done", init_done_o, 1'b0);
            @(posedge clk); #1;
        end
        sweep();
        mon_en = 1'b1;
        touch_valid_i = 1'b1; touch_set_i = 6'd7; touch_way_i = 2'd2;
        vic_valid_i = 1'b1; vic_set_i = 6'd7;
        repeat (12) step(1'b1);
        touch_valid_i = 1'b0; vic_valid_i = 1'b0;
        repeat (4) step(1'b0);
        chk("sb_final", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lru_matrix_ctrl.md
Name: lru_matrix_ctrl

Overview:
Controller for the per-set matrix-LRU memory of the cache.
- Forwards the post-reset initialisation sweep from load_sm to the memory write port.
- Then arbitrates two requesters, "touch" (hit/fill update) and "victim" (replacement query), onto a single-port synchronous LRU RAM.
- Touches are performed as read-modify-write; victim queries are read-only.
- Sits between load_sm, the cache control FSM and the LRU RAM.

Parameters:
SET_BITS, 6, set index width (memory depth 2**SET_BITS)
WAYS, 4, associativity; power of two, >=2
WAY_BITS, $clog2(WAYS), way index width
MATRIX_WIDTH, WAYS*WAYS, matrix vector width; bit i*WAYS+j = 1 means way i is more recent than way j

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous, active-high reset
init_we_i  in  1  load_sm write strobe
init_addr_i  in  SET_BITS  load_sm set address
init_vect_i  in  MATRIX_WIDTH  load_sm init vector
init_ready_i  in  1  load_sm sweep complete
touch_valid_i  in  1  touch request
touch_set_i  in  SET_BITS  set to update
touch_way_i  in  WAY_BITS  way becoming most-recent
touch_ready_o  out  1  touch accepted this cycle
vic_valid_i  in  1  victim query request
vic_set_i  in  SET_BITS  set to query
vic_ready_o  out  1  query accepted this cycle
vic_rsp_valid_o  out  1  victim result valid (1-cycle pulse)
vic_way_o  out  WAY_BITS  victim way
mem_re_o  out  1  RAM read enable
mem_raddr_o  out  SET_BITS  RAM read address
mem_rdata_i  in  MATRIX_WIDTH  RAM read data, valid the cycle after mem_re_o
mem_we_o  out  1  RAM write enable
mem_waddr_o  out  SET_BITS  RAM write address
mem_wdata_o  out  MATRIX_WIDTH  RAM write data
init_done_o  out  1  controller left INIT

Behaviour:
- Reset (async assert, sync release):
  - state=INIT; all registered outputs 0; arbitration pointer prefers touch.
  - An in-flight op is dropped with no write and no response.
- States:
  - INIT:
    - mem_we_o/mem_waddr_o/mem_wdata_o driven combinationally from init_we_i/init_addr_i/init_vect_i.
    - touch_ready_o=vic_ready_o=0.
    - Goes to IDLE on the edge where init_ready_i=1; init_done_o=1 from the next cycle.
    - INIT is left only once per reset.
  - IDLE:
    - Grant is combinational. ready is asserted for exactly one requester whose valid is high.
    - Both valid: grant the one not granted last (round-robin), then flip the pointer.
    - Set/way/type are latched on the handshake edge (cycle N).
  - RD (N+1): mem_re_o=1, mem_raddr_o=latched set.
  - UPD (N+2), mem_rdata_i valid:
    - Touch: mem_we_o=1, mem_waddr_o=set, mem_wdata_o=rdata with row w forced to 1 (except diagonal bit w*WAYS+w=0) and column w cleared in every row.
    - Victim: vic_rsp_valid_o=1; vic_way_o = lowest way whose row (diagonal excluded) is all zero; if none, 0.
    - Then to IDLE.
- Throughput: one op per 3 cycles. Because the write completes before the next read, there are no RAW hazards and no bypass path is needed.
- Idle outputs: outside INIT/UPD, mem_we_o=0 and mem_wdata_o=0. mem_re_o=0 outside RD.
- Requests held while not ready stay pending; requesters hold valid and payload stable until ready.
- vic_way_o holds its last value when vic_rsp_valid_o=0 (reset value 0).
- Data-path widths are exact. No arithmetic overflow cases exist.

Test Plan:
- Reset, then load_sm sweep of 64 sets with vector 0x08CE, init_ready_i at end:
  - mem_we_o mirrors init_we_i each cycle; no ready asserted during INIT;
  - init_done_o=1 one cycle after init_ready_i.
- WAYS=4, set 5 holds 0x08CE; touch way 3 at cycle N:
  - mem_re_o at N+1 with addr 5;
  - mem_we_o at N+2, addr 5, data 0x7046.
- Victim query on set 5 after the touch: vic_rsp_valid_o pulse at N+2, vic_way_o=2. On untouched set 0x08CE: vic_way_o=3.
- touch_valid_i and vic_valid_i both held high continuously:
  - grants alternate touch, victim, touch, …, every 3 cycles;
  - touch wins first after reset.
- Victim query on corrupt vector 0xFFFF (no zero row) -> vic_way_o=0.
- Assert rst_i in RD state of a touch:
  - no mem_we_o follows; state returns to INIT; outputs 0 asynchronously;
  - new sweep required before any ready.
